msrv32_fetch_unit: RTL and testbench
====================================

// Module: msrv32_fetch_unit
// PURPOSE
//  Instruction-fetch stage between the PC mux and instruction memory. Holds the architectural PC,
//  issues one outstanding IMEM request per instruction and buffers the returned word for decode.
//  pc_out feeds the PC mux pc_in; the PC mux next-address (pc_mux_in) is the next fetch address.
//  Covers stall, flush, misaligned-target and IMEM-timeout conditions.
// PARAMETERS
//  BOOT_ADDR       32'h0000_0000  first fetch address after reset
//  NOP_INSTR       32'h0000_0013  value on instr_out when no valid instruction (addi x0,x0,0)
//  TIMEOUT_CYCLES  64             max WAIT cycles before IMEM fault (>=2, counter 8 bits)
// PORTS
//  clk_in             in   1   clock, rising edge
//  rst_n_in           in   1   asynchronous, active-low reset
//  pc_mux_in          in   32  next fetch address from PC mux
//  misaligned_in      in   1   PC mux flags pc_mux_in misaligned (branch target bit1 set)
//  stall_in           in   1   decode not ready; instruction must be held
//  flush_in           in   1   trap/redirect: discard in-flight or held instruction
//  imem_req_out       out  1   IMEM request valid
//  imem_addr_out      out  32  IMEM word address (bits[1:0] always 2'b00)
//  imem_gnt_in        in   1   IMEM accepts request this cycle
//  imem_rvalid_in     in   1   IMEM read data valid
//  imem_rdata_in      in   32  IMEM read data
//  pc_out             out  32  PC of instruction in fetch (last granted address)
//  instr_out          out  32  fetched instruction, NOP_INSTR when instr_valid_out=0
//  instr_valid_out    out  1   instr_out valid; consumed on instr_valid_out & !stall_in
//  misaligned_out     out  1   sticky: fetch blocked by misaligned target
//  imem_fault_out     out  1   sticky: IMEM response timeout
// BEHAVIOUR
//  Reset (async assert, sync release): state=ISSUE, first_fetch=1, pc_out=BOOT_ADDR,
//   instr_out=NOP_INSTR, instr_valid_out=0, misaligned_out=0, imem_fault_out=0, timeout cnt=0.
//  imem_req_out=1 only in ISSUE and not blocked; imem_addr_out = first_fetch ? BOOT_ADDR : pc_mux_in.
//  States:
//   ISSUE: if !first_fetch & misaligned_in -> no request, misaligned_out<=1, -> HALT.
//          else on imem_gnt_in: pc_out<=imem_addr_out, first_fetch<=0, cnt<=0, -> WAIT.
//   WAIT:  on imem_rvalid_in: instr_out<=imem_rdata_in, instr_valid_out<=1, -> HOLD.
//          else cnt++; cnt==TIMEOUT_CYCLES-1 -> imem_fault_out<=1, -> HALT.
//   HOLD:  !stall_in: instr_valid_out<=0, instr_out<=NOP_INSTR, -> ISSUE (next req following cycle).
//          stall_in: hold instr_out/pc_out/valid unchanged.
//   DRAIN: request outstanding but flushed; on imem_rvalid_in drop data -> ISSUE; timeout as WAIT.
//   HALT:  no requests; leave only via flush_in.
//  flush_in (priority over all above, same edge): instr_valid_out<=0, instr_out<=NOP_INSTR;
//   WAIT -> DRAIN; DRAIN stays DRAIN; HOLD/ISSUE/HALT -> ISSUE; clears misaligned_out, imem_fault_out.
//   flush in ISSUE with gnt same cycle: grant honoured, -> DRAIN (pc_out still updated).
//  flush_in & imem_rvalid_in in WAIT: data discarded, -> ISSUE.
//  Latency: grant-to-valid = rvalid latency + 1 cycle (registered). Max 1 outstanding request.
//  pc_out changes only on grant; stable while WAIT/HOLD so PC mux pc_plus_4 is stable.
//  Timeout counter saturates; never wraps. PC arithmetic is PC mux's, none here.
//  Reset asserted mid-transaction: all state to reset values; a late rvalid after reset is ignored
//   because state is ISSUE (rvalid only sampled in WAIT/DRAIN).
// STRUCTURE
//  Package msrv32_fetch_pkg: state enum {ISSUE,WAIT,HOLD,DRAIN,HALT}, NOP_INSTR constant.
//  One sub-module: msrv32_fetch_timer (8-bit saturating counter, clear/enable, expired flag).
//  Remaining FSM, PC and instruction registers in this module.
// TESTING
//  Reset release, gnt=1, rvalid 1 cycle later with 32'h00500093 -> addr 0x0, pc_out=0, valid=1, instr 00500093.
//  Back-to-back, pc_mux_in=pc_out+4, stall=0 -> addresses 0x0,0x4,0x8; one req per instr, valid pulses.
//  stall_in=1 for 3 cycles in HOLD -> instr_out, pc_out, valid held; no imem_req_out; resumes after.
//  flush_in during WAIT, rvalid arrives 2 cycles later -> data dropped, valid stays 0, next req at pc_mux_in.
//  misaligned_in=1 with pc_mux_in=0x102 -> no req, misaligned_out=1; flush_in clears, refetch.
//  rvalid withheld 64 cycles -> imem_fault_out=1 at cycle 64, no new req until flush_in.

Source files
------------

// File: rtl/msrv32_fetch_pkg.sv
// Shared types and constants for the msrv32 instruction-fetch stage.
package msrv32_fetch_pkg;

  typedef enum logic [2:0] {
    ISSUE = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned TIMER_W   = 8;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/msrv32_fetch_if.sv
// Fetch-stage bus: PC mux inputs, pipeline control, IMEM handshake and decode outputs.
interface msrv32_fetch_if;
  logic [31:0] pc_mux_in;
  logic        misaligned_in;
  logic        stall_in;
  logic        flush_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid_out;
  logic        misaligned_out;
  logic        imem_fault_out;

  modport master (
    input  pc_mux_in, misaligned_in, stall_in, flush_in,
    input  imem_gnt_in, imem_rvalid_in, imem_rdata_in,
    output imem_req_out, imem_addr_out,
    output pc_out, instr_out, instr_valid_out, misaligned_out, imem_fault_out
  );

  modport slave (
    output pc_mux_in, misaligned_in, stall_in, flush_in,
    output imem_gnt_in, imem_rvalid_in, imem_rdata_in,
    input  imem_req_out, imem_addr_out,
    input  pc_out, instr_out, instr_valid_out, misaligned_out, imem_fault_out
  );
endinterface

// File: rtl/msrv32_fetch_timer.sv
// Saturating response-wait counter; expired once LIMIT-1 waiting cycles have been counted.
module msrv32_fetch_timer
  import msrv32_fetch_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // >= so a count that runs past LAST (e.g. flush held in DRAIN) still trips later
  assign expired = (cnt >= LAST);

endmodule

// File: rtl/msrv32_fetch_unit.sv
// Instruction-fetch stage: one outstanding IMEM request, buffers the returned word for decode.
//
//   state | meaning
//   ISSUE | request pc_mux_in (BOOT_ADDR on first fetch), wait for grant
//   WAIT  | request granted, waiting for rvalid
//   HOLD  | instruction valid, held until decode takes it
//   DRAIN | flushed request still outstanding, discard its response
//   HALT  | misaligned target or IMEM timeout, wait for flush
module msrv32_fetch_unit #(
  parameter logic [31:0] BOOT_ADDR      = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR      = msrv32_fetch_pkg::NOP_INSTR,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  msrv32_fetch_if.master       bus
);

  import msrv32_fetch_pkg::*;

  fetch_state_e state;
  logic         first_fetch;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         misaligned_q;
  logic         fault_q;

  logic         blocked;
  logic         req;
  logic [31:0]  addr;
  logic         grant;
  logic         expired;
  logic         waiting;

  assign blocked = !first_fetch && bus.misaligned_in;
  assign req     = (state == ISSUE) && !blocked;
  assign addr    = word_align(first_fetch ? BOOT_ADDR : bus.pc_mux_in);
  assign grant   = req && bus.imem_gnt_in;
  assign waiting = ((state == WAIT) || (state == DRAIN)) && !bus.imem_rvalid_in;

  msrv32_fetch_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear    (grant),
    .enable   (waiting),
    .expired  (expired)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ISSUE;
      first_fetch  <= 1'b1;
      pc_q         <= BOOT_ADDR;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (grant) begin
            pc_q        <= addr;
            first_fetch <= 1'b0;
            state       <= bus.flush_in ? DRAIN : WAIT;
          end else if (blocked && !bus.flush_in) begin
            misaligned_q <= 1'b1;
            state        <= HALT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid_in) begin
            if (bus.flush_in) begin
              state <= ISSUE;
            end else begin
              instr_q <= bus.imem_rdata_in;
              valid_q <= 1'b1;
              state   <= HOLD;
            end
          end else if (bus.flush_in) begin
            state <= DRAIN;
          end else if (expired) begin
            fault_q <= 1'b1;
            state   <= HALT;
          end
        end
        HOLD: begin
          if (bus.flush_in || !bus.stall_in) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            state   <= ISSUE;
          end
        end
        DRAIN: begin
          if (bus.imem_rvalid_in) begin
            state <= ISSUE;
          end else if (expired && !bus.flush_in) begin
            fault_q <= 1'b1;
            state   <= HALT;
          end
        end
        HALT: begin
          if (bus.flush_in) state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase

      // flush overrides whatever the state logic chose for the datapath and sticky flags
      if (bus.flush_in) begin
        valid_q      <= 1'b0;
        instr_q      <= NOP_INSTR;
        misaligned_q <= 1'b0;
        fault_q      <= 1'b0;
      end
    end
  end

  assign bus.imem_req_out    = req;
  assign bus.imem_addr_out   = addr;
  assign bus.pc_out          = pc_q;
  assign bus.instr_out       = instr_q;
  assign bus.instr_valid_out = valid_q;
  assign bus.misaligned_out  = misaligned_q;
  assign bus.imem_fault_out  = fault_q;

endmodule

// File: tb/tb_msrv32_fetch_unit.sv
// Directed self-checking bench for msrv32_fetch_unit.
module tb_msrv32_fetch_unit;
  import msrv32_fetch_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  msrv32_fetch_if bus ();

  msrv32_fetch_unit dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in ISSUE, ends in HOLD with the word valid.
  task automatic fetch(input logic [31:0] mux, input logic [31:0] exp_addr, input logic [31:0] data);
    bus.pc_mux_in = mux;
    #1;
    check("issue_req", bus.imem_req_out, 1);
    check("issue_addr", bus.imem_addr_out, exp_addr);
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in = 1'b0;
    check("wait_req", bus.imem_req_out, 0);
    check("wait_pc", bus.pc_out, exp_addr);
    check("wait_valid", bus.instr_valid_out, 0);
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = data;
    step();
    bus.imem_rvalid_in = 1'b0;
    bus.imem_rdata_in  = 32'h0;
    check("hold_valid", bus.instr_valid_out, 1);
    check("hold_instr", bus.instr_out, data);
    check("hold_pc", bus.pc_out, exp_addr);
    check("hold_req", bus.imem_req_out, 0);
  endtask

  task automatic consume();
    step();
    check("consume_valid", bus.instr_valid_out, 0);
    check("consume_instr", bus.instr_out, NOP_INSTR);
    check("consume_req", bus.imem_req_out, 1);
  endtask

  initial begin
    bus.pc_mux_in      = 32'h0;
    bus.misaligned_in  = 1'b0;
    bus.stall_in       = 1'b0;
    bus.flush_in       = 1'b0;
    bus.imem_gnt_in    = 1'b0;
    bus.imem_rvalid_in = 1'b0;
    bus.imem_rdata_in  = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_instr", bus.instr_out, NOP_INSTR);
    check("rst_valid", bus.instr_valid_out, 0);
    check("rst_misal", bus.misaligned_out, 0);
    check("rst_fault", bus.imem_fault_out, 0);
    check("rst_req", bus.imem_req_out, 1);
    rst_n = 1'b1;

    // first fetch goes to BOOT_ADDR whatever the PC mux says
    fetch(32'h40, 32'h0, 32'h0050_0093);
    consume();
    fetch(32'h4, 32'h4, 32'h0010_0113);
    consume();
    fetch(32'h8, 32'h8, 32'h0020_0193);

    // stall in HOLD
    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", bus.instr_valid_out, 1);
      check("stall_instr", bus.instr_out, 32'h0020_0193);
      check("stall_pc", bus.pc_out, 32'h8);
      check("stall_req", bus.imem_req_out, 0);
    end
    bus.stall_in  = 1'b0;
    bus.pc_mux_in = 32'hC;
    step();
    check("resume_valid", bus.instr_valid_out, 0);
    check("resume_req", bus.imem_req_out, 1);
    check("resume_addr", bus.imem_addr_out, 32'hC);

    // flush during WAIT, response arrives two cycles later and is dropped
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in = 1'b0;
    bus.flush_in    = 1'b1;
    step();
    bus.flush_in = 1'b0;
    check("drain_req", bus.imem_req_out, 0);
    check("drain_valid", bus.instr_valid_out, 0);
    check("drain_pc", bus.pc_out, 32'hC);
    step();
    check("drain_req2", bus.imem_req_out, 0);
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid_in = 1'b0;
    bus.imem_rdata_in  = 32'h0;
    check("drop_valid", bus.instr_valid_out, 0);
    check("drop_instr", bus.instr_out, NOP_INSTR);
    fetch(32'h10, 32'h10, 32'h00A0_0113);
    consume();

    // misaligned target
    bus.pc_mux_in     = 32'h102;
    bus.misaligned_in = 1'b1;
    #1;
    check("misal_noreq", bus.imem_req_out, 0);
    step();
    check("misal_flag", bus.misaligned_out, 1);
    bus.misaligned_in = 1'b0;
    bus.pc_mux_in     = 32'h104;
    #1;
    check("halt_noreq", bus.imem_req_out, 0);
    step();
    check("misal_sticky", bus.misaligned_out, 1);
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    check("misal_clear", bus.misaligned_out, 0);
    fetch(32'h104, 32'h104, 32'h0030_0213);
    consume();

    // IMEM timeout: fault on the 64th waiting cycle
    bus.pc_mux_in   = 32'h200;
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in = 1'b0;
    repeat (63) step();
    check("tmo_before", bus.imem_fault_out, 0);
    step();
    check("tmo_fault", bus.imem_fault_out, 1);
    check("tmo_noreq", bus.imem_req_out, 0);
    repeat (3) step();
    check("tmo_halt_req", bus.imem_req_out, 0);
    check("tmo_sticky", bus.imem_fault_out, 1);
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    check("tmo_clear", bus.imem_fault_out, 0);
    check("tmo_refetch", bus.imem_req_out, 1);

    // flush together with rvalid in WAIT: data discarded, straight back to ISSUE
    bus.pc_mux_in   = 32'h300;
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in    = 1'b0;
    bus.flush_in       = 1'b1;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = 32'h1234_5678;
    step();
    bus.flush_in       = 1'b0;
    bus.imem_rvalid_in = 1'b0;
    check("fr_valid", bus.instr_valid_out, 0);
    check("fr_req", bus.imem_req_out, 1);
    check("fr_pc", bus.pc_out, 32'h300);

    // reset mid-transaction, late rvalid ignored
    bus.imem_gnt_in = 1'b1;
    step();
    bus.imem_gnt_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_pc", bus.pc_out, 32'h0);
    check("mrst_addr", bus.imem_addr_out, 32'h0);
    step();
    rst_n              = 1'b1;
    bus.pc_mux_in      = 32'h500;
    bus.imem_rvalid_in = 1'b1;
    bus.imem_rdata_in  = 32'hCAFE_F00D;
    step();
    bus.imem_rvalid_in = 1'b0;
    bus.imem_rdata_in  = 32'h0;
    check("late_valid", bus.instr_valid_out, 0);
    check("late_instr", bus.instr_out, NOP_INSTR);
    fetch(32'h500, 32'h0, 32'h0040_0293);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
